// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Purpose:
//   Walks a combinational N_IN-input logic gate through every input vector in
//   ascending order. For each vector it holds dut_in for SETTLE_CYCLES cycles,
//   then samples dut_out on SAMPLES consecutive cycles. The final sample of
//   each vector is written into an observed truth table in hex-ID order.
//   Vector i lands at bit 2**N_IN-1-i, so gate ID 0xC0 means "output high for
//   inputs 000 and 001 only". The observed table is compared against an
//   expected table that is latched when the sweep starts.
//
// Ports:
//   clk       in   single clock
//   rst_n     in   synchronous, active-low reset
//   start     in   one-cycle sweep request, honoured only in IDLE
//   abort     in   stop the sweep; return to IDLE without a done pulse
//   expected  in   expected truth table (hex-ID order), latched on start
//   dut_out   in   output of the gate under test
//   dut_in    out  input vector driven to the gate
//   busy      out  high while settling or sampling
//   done      out  one-cycle pulse when a sweep completes
//   observed  out  captured truth table (hex-ID order)
//   mismatch  out  observed XOR latched expected, per vector
//   unstable  out  vectors whose samples disagreed with the first sample
//   pass      out  mismatch==0 and unstable==0; valid from done to next start
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int N_IN          = 3,
    parameter int SETTLE_CYCLES = 4,   // 1..255
    parameter int SAMPLES       = 2    // 1..15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   observed,
    output logic [2**N_IN-1:0]   mismatch,
    output logic [2**N_IN-1:0]   unstable,
    output logic                 pass
);

    localparam int W = 2**N_IN;

    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]      SAMPLE_LAST = 4'(SAMPLES - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN-1:0]   dut_in_q, dut_in_d;
    logic [7:0]        settle_cnt_q, settle_cnt_d;
    logic [3:0]        sample_cnt_q, sample_cnt_d;
    logic              ref_q, ref_d;
    logic [W-1:0]      exp_q, exp_d;
    logic [W-1:0]      observed_q, observed_d;
    logic [W-1:0]      mismatch_q, mismatch_d;
    logic [W-1:0]      unstable_q, unstable_d;
    logic              pass_q, pass_d;

    // Shared decode terms.
    logic              start_ok;
    logic              settle_last;
    logic              sample_last;
    logic              idx_last;
    logic              exp_bit;
    logic [W-1:0]      vec_mask;

    // Sweep only begins when abort is not asserted in the same cycle.
    assign start_ok    = start && !abort;
    assign settle_last = (settle_cnt_q == SETTLE_LAST);
    assign sample_last = (sample_cnt_q == SAMPLE_LAST);
    assign idx_last    = (idx_q == IDX_LAST);

    // One-hot mask of the truth-table bit owned by the current vector.
    // Hex-ID order places vector i at bit W-1-i.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_mask
            assign vec_mask[gi] = (idx_q == N_IN'(W - 1 - gi));
        end
    endgenerate

    assign exp_bit = |(exp_q & vec_mask);

    // -------------------------------------------------------------------------
    // State register and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            dut_in_q     <= '0;
            settle_cnt_q <= '0;
            sample_cnt_q <= '0;
            ref_q        <= 1'b0;
            exp_q        <= '0;
            observed_q   <= '0;
            mismatch_q   <= '0;
            unstable_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dut_in_q     <= dut_in_d;
            settle_cnt_q <= settle_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            ref_q        <= ref_d;
            exp_q        <= exp_d;
            observed_q   <= observed_d;
            mismatch_q   <= mismatch_d;
            unstable_q   <= unstable_d;
            pass_q       <= pass_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (settle_last) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (sample_last) begin
                    state_d = idx_last ? S_DONE : S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath next-value logic (counters, vector, captured results)
    // -------------------------------------------------------------------------
    always_comb begin
        idx_d        = idx_q;
        dut_in_d     = dut_in_q;
        settle_cnt_d = settle_cnt_q;
        sample_cnt_d = sample_cnt_q;
        ref_d        = ref_q;
        exp_d        = exp_q;
        observed_d   = observed_q;
        mismatch_d   = mismatch_q;
        unstable_d   = unstable_q;
        pass_d       = pass_q;

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    exp_d        = expected;
                    observed_d   = '0;
                    mismatch_d   = '0;
                    unstable_d   = '0;
                    pass_d       = 1'b0;
                    idx_d        = '0;
                    dut_in_d     = '0;
                    settle_cnt_d = '0;
                    sample_cnt_d = '0;
                end
            end

            S_SETTLE: begin
                if (abort) begin
                    dut_in_d = '0;
                    pass_d   = 1'b0;
                end else if (settle_last) begin
                    settle_cnt_d = '0;
                    sample_cnt_d = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end

            S_SAMPLE: begin
                if (abort) begin
                    // Partial results are deliberately left untouched.
                    dut_in_d = '0;
                    pass_d   = 1'b0;
                end else begin
                    sample_cnt_d = sample_cnt_q + 4'd1;

                    // First sample is the reference; later ones are only
                    // compared against it.
                    if (sample_cnt_q == 4'd0) begin
                        ref_d = dut_out;
                    end else if (dut_out != ref_q) begin
                        unstable_d = unstable_q | vec_mask;
                    end

                    if (sample_last) begin
                        observed_d = (observed_q & ~vec_mask)
                                   | (dut_out ? vec_mask : '0);
                        mismatch_d = (mismatch_q & ~vec_mask)
                                   | ((dut_out ^ exp_bit) ? vec_mask : '0);
                        sample_cnt_d = '0;

                        if (idx_last) begin
                            // Verdict uses the values being written this edge,
                            // so the last vector is included.
                            dut_in_d = '0;
                            pass_d   = (mismatch_d == '0) && (unstable_d == '0);
                        end else begin
                            idx_d        = idx_q + 1'b1;
                            dut_in_d     = idx_q + 1'b1;
                            settle_cnt_d = '0;
                        end
                    end
                end
            end

            S_DONE: begin
                dut_in_d = '0;
            end

            default: begin
                dut_in_d = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SETTLE: busy = 1'b1;
            S_SAMPLE: busy = 1'b1;
            S_DONE:   done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign dut_in   = dut_in_q;
    assign observed = observed_q;
    assign mismatch = mismatch_q;
    assign unstable = unstable_q;
    assign pass     = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// tb_truth_table_sweeper
//
// Directed bench for truth_table_sweeper with the default parameters
// (N_IN=3, SETTLE_CYCLES=4, SAMPLES=2). The gate under test is modelled as
// ID 0xC0 (out = ~in1 & ~in2), optionally forced stuck-at-0 or glitched on
// the second sample of vector 5. Outputs are sampled 1 time unit after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [7:0] expected;
    logic       dut_out;
    logic [2:0] dut_in;
    logic       busy;
    logic       done;
    logic [7:0] observed;
    logic [7:0] mismatch;
    logic [7:0] unstable;
    logic       pass;

    logic       stuck;
    logic       glitch;
    logic       gate_out;

    int n_vec;
    int n_err;

    truth_table_sweeper #(
        .N_IN          (3),
        .SETTLE_CYCLES (4),
        .SAMPLES       (2)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .expected (expected),
        .dut_out  (dut_out),
        .dut_in   (dut_in),
        .busy     (busy),
        .done     (done),
        .observed (observed),
        .mismatch (mismatch),
        .unstable (unstable),
        .pass     (pass)
    );

    // Gate ID 0xC0: high only for inputs 000 and 001.
    assign gate_out = ~dut_in[1] & ~dut_in[2];
    assign dut_out  = (stuck ? 1'b0 : gate_out) ^ glitch;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep from a start pulse. Checks dut_in/busy/done every cycle
    // against the 6-cycle-per-vector schedule and done 48 edges after the
    // start edge. Optional disturbances: abort or reset at sweep cycle c,
    // glitch on vector 5's second sample, start+expected change mid-sweep.
    task automatic run_sweep(input int abort_at, input int rst_at,
                             input bit glitch_on, input bit disturb);
        bit seen_done;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 48; c++) begin
            check($sformatf("dut_in c%0d", c), 32'(dut_in), 32'(c / 6));
            check($sformatf("busy c%0d", c), 32'(busy), 32'd1);
            check($sformatf("done c%0d", c), 32'(done), 32'd0);
            if (abort_at == c) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check("abort busy", 32'(busy), 32'd0);
                check("abort dut_in", 32'(dut_in), 32'd0);
                check("abort pass", 32'(pass), 32'd0);
                seen_done = 1'b0;
                for (int k = 0; k < 52; k++) begin
                    if (done) seen_done = 1'b1;
                    step();
                end
                check("abort no done", 32'(seen_done), 32'd0);
                return;
            end
            if (rst_at == c) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check("rst dut_in", 32'(dut_in), 32'd0);
                check("rst busy", 32'(busy), 32'd0);
                check("rst done", 32'(done), 32'd0);
                check("rst observed", 32'(observed), 32'd0);
                check("rst mismatch", 32'(mismatch), 32'd0);
                check("rst unstable", 32'(unstable), 32'd0);
                check("rst pass", 32'(pass), 32'd0);
                return;
            end
            if (glitch_on && c == 35) glitch = 1'b1;
            if (c == 36) glitch = 1'b0;
            if (disturb && c == 10) begin
                start    = 1'b1;
                expected = 8'hFF;
            end
            if (c == 11) start = 1'b0;
            step();
        end
        check("done pulse", 32'(done), 32'd1);
        check("done busy", 32'(busy), 32'd0);
        check("done dut_in", 32'(dut_in), 32'd0);
        step();
        check("done end", 32'(done), 32'd0);
        check("idle dut_in", 32'(dut_in), 32'd0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        expected = 8'h00;
        stuck    = 1'b0;
        glitch   = 1'b0;
        step();
        step();

        // Reset state
        check("reset dut_in", 32'(dut_in), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset observed", 32'(observed), 32'd0);
        check("reset mismatch", 32'(mismatch), 32'd0);
        check("reset unstable", 32'(unstable), 32'd0);
        check("reset pass", 32'(pass), 32'd0);
        rst_n = 1'b1;
        step();

        // Correct gate
        expected = 8'hC0;
        run_sweep(-1, -1, 1'b0, 1'b0);
        $display("sweep good-gate: obs=%h mis=%h uns=%h pass=%b", observed, mismatch, unstable, pass);
        check("good observed", 32'(observed), 32'hC0);
        check("good mismatch", 32'(mismatch), 32'h00);
        check("good unstable", 32'(unstable), 32'h00);
        check("good pass", 32'(pass), 32'd1);

        // Stuck-at-0 gate
        stuck = 1'b1;
        run_sweep(-1, -1, 1'b0, 1'b0);
        stuck = 1'b0;
        $display("sweep stuck0: obs=%h mis=%h uns=%h pass=%b", observed, mismatch, unstable, pass);
        check("stuck observed", 32'(observed), 32'h00);
        check("stuck mismatch", 32'(mismatch), 32'hC0);
        check("stuck unstable", 32'(unstable), 32'h00);
        check("stuck pass", 32'(pass), 32'd0);

        // Glitch on vector 5: samples 0 then 1
        run_sweep(-1, -1, 1'b1, 1'b0);
        $display("sweep glitch: obs=%h mis=%h uns=%h pass=%b", observed, mismatch, unstable, pass);
        check("glitch observed", 32'(observed), 32'hC4);
        check("glitch mismatch", 32'(mismatch), 32'h04);
        check("glitch unstable", 32'(unstable), 32'h04);
        check("glitch pass", 32'(pass), 32'd0);

        // start while busy and expected change mid-sweep
        run_sweep(-1, -1, 1'b0, 1'b1);
        expected = 8'hC0;
        $display("sweep disturb: obs=%h mis=%h uns=%h pass=%b", observed, mismatch, unstable, pass);
        check("disturb observed", 32'(observed), 32'hC0);
        check("disturb mismatch", 32'(mismatch), 32'h00);
        check("disturb pass", 32'(pass), 32'd1);

        // Abort during SETTLE of vector 3
        run_sweep(19, -1, 1'b0, 1'b0);
        $display("sweep abort: obs=%h mis=%h uns=%h pass=%b", observed, mismatch, unstable, pass);
        check("abort obs[7:5]", 32'(observed[7:5]), 32'b110);
        check("abort observed", 32'(observed), 32'hC0);
        check("abort mismatch", 32'(mismatch), 32'h00);
        check("abort unstable", 32'(unstable), 32'h00);

        // abort and start together in IDLE: no sweep
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        $display("start+abort: busy=%b dut_in=%0d", busy, dut_in);
        check("start+abort busy", 32'(busy), 32'd0);
        step();
        check("start+abort busy2", 32'(busy), 32'd0);

        // Restart after abort: full sweep
        run_sweep(-1, -1, 1'b0, 1'b0);
        $display("sweep restart: obs=%h mis=%h uns=%h pass=%b", observed, mismatch, unstable, pass);
        check("restart observed", 32'(observed), 32'hC0);
        check("restart pass", 32'(pass), 32'd1);

        // Reset mid-sweep at cycle 20
        run_sweep(-1, 20, 1'b0, 1'b0);
        $display("sweep reset: obs=%h busy=%b pass=%b", observed, busy, pass);
        step();
        check("post-rst busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that drives a combinational N-input logic gate through every input combination in ascending order, waits a settle interval, then samples the gate output.
- Captures an observed truth table in hex-ID order and compares it with an expected truth table.
- Sits between a test/characterisation controller and one logic-gate instance (e.g. a 3-input gate with ID 0xC0).

Parameters:
- N_IN, 3, number of gate inputs; the truth table is 2**N_IN bits wide.
- SETTLE_CYCLES, 4, cycles dut_in is held before sampling starts; range 1..255.
- SAMPLES, 2, consecutive samples taken per vector; range 1..15.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  ends the sweep and returns to IDLE; done is not asserted.
- expected  input  2**N_IN  expected truth table, hex-ID order.
- dut_out  input  1  gate output under test.
- dut_in  output  N_IN  input vector driven to the gate.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- observed  output  2**N_IN  captured truth table, hex-ID order.
- mismatch  output  2**N_IN  observed XOR expected_latched.
- unstable  output  2**N_IN  vector whose samples disagreed.
- pass  output  1  high when mismatch==0 and unstable==0; valid from done until the next start.

Behaviour:
- Reset and clock:
  - One clock; reset is synchronous and active-low.
  - On a clock edge with rst_n=0: state=IDLE, and dut_in, observed, mismatch, unstable, busy, done and pass are all 0.
- Bit-order rule: vector i (dut_in=i) maps to bit index 2**N_IN-1-i. For example, ID 0xC0 means out=1 only for inputs 000 and 001.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - dut_in=0.
  - Results hold their last values.
  - start=1 does the following: latch expected; clear observed, mismatch, unstable and pass; set idx=0; go to SETTLE next cycle with dut_in=0.
- SETTLE:
  - dut_in=idx is registered and stable for the whole state.
  - Stays in SETTLE exactly SETTLE_CYCLES cycles, then goes to SAMPLE.
- SAMPLE:
  - Stays exactly SAMPLES cycles; dut_out is sampled on each of these cycles.
  - The first sample is the reference sample. A later sample that differs sets unstable[bit(idx)].
  - At the final sample cycle: observed[bit(idx)] is set to the last sample, and mismatch[bit(idx)] is updated.
  - Then, if idx==2**N_IN-1, go to DONE. Otherwise idx+1 and back to SETTLE; dut_in changes on that same edge.
- DONE:
  - Lasts one cycle, with done=1 and pass valid.
  - Then go to IDLE.
  - start during DONE is ignored.
- Latency:
  - Each vector takes SETTLE_CYCLES+SAMPLES cycles.
  - start sampled at edge t gives done=1 in cycle t+1+2**N_IN*(SETTLE_CYCLES+SAMPLES).
  - With the defaults this is t+49.
- start while busy: ignored, with no restart and no effect on results.
- abort:
  - Applies in SETTLE or SAMPLE.
  - Next cycle: IDLE, dut_in=0, busy=0, no done pulse, pass=0.
  - Partial observed, mismatch and unstable bits are kept.
  - abort in IDLE or DONE has no effect.
  - abort and start in the same IDLE cycle: abort wins and no sweep starts.
- Reset mid-sweep: same result as power-on reset on that edge.
- expected changes mid-sweep: no effect, because it is latched at start.
- Counters:
  - settle counter is 8-bit; sample counter is 4-bit; idx is N_IN bits wide.
  - None of the counters wraps within a sweep.

Test Plan:
- Correct gate: model dut_out for ID 0xC0 (out=~in1&~in2), expected=8'hC0, start -> observed=8'hC0, mismatch=0, unstable=0, pass=1, done pulses exactly 49 cycles after the start edge.
- Stuck-at-0 gate: dut_out=0, expected=8'hC0 -> observed=8'h00, mismatch=8'hC0, pass=0.
- Glitch during sampling: toggle dut_out between the two SAMPLE cycles of vector 5 -> unstable=8'h04, pass=0, observed bit 2 equals the second sample.
- Sequencing check: monitor dut_in -> sequence 0..7, each value held exactly 6 cycles; busy=1 throughout the sweep; dut_in=0 after done.
- Abort and restart: abort during SETTLE of vector 3 -> IDLE next cycle, no done pulse, pass=0, observed[7:5] holds captured data. A new start then gives a full 49-cycle sweep.
- Ignored and reset events:
  - start pulsed while busy, and expected changed mid-sweep -> results match the original expected, and done timing is unchanged.
  - rst_n=0 at cycle 20 -> all outputs 0 next cycle.
